// File: rtl/branch_ctrl_if.sv
// Branch request channel, fetch redirect channel and resolution status of branch_ctrl.
// Latency: none, signal bundle only.
// Backpressure: br_valid/br_ready on requests, redir_valid/redir_ready on redirects.
interface branch_ctrl_if;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_funct3;
    logic [31:0] br_rs1;
    logic [31:0] br_rs2;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_target;
    logic        flush;
    logic        done;
    logic        taken;
    logic        illegal;
    logic [15:0] taken_count;

    modport master (
        output br_valid, br_funct3, br_rs1, br_rs2, br_pc, br_imm, redir_ready,
        input  br_ready, redir_valid, redir_target, flush, done, taken, illegal, taken_count
    );

    modport slave (
        input  br_valid, br_funct3, br_rs1, br_rs2, br_pc, br_imm, redir_ready,
        output br_ready, redir_valid, redir_target, flush, done, taken, illegal, taken_count
    );
endinterface

// File: rtl/branch_ctrl.sv
// Resolves conditional branches and issues a fetch redirect plus flush window on taken ones.
// Latency: done/taken one cycle after acceptance, redir_valid two cycles after acceptance.
// Backpressure: one branch in flight; br_ready only in IDLE, redirect held until redir_ready.
module branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    branch_ctrl_if.slave br
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

    state_t      state_q;
    logic [2:0]  funct3_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] pc_q;
    logic [31:0] imm_q;
    logic [31:0] target_q;
    logic [15:0] count_q;
    logic [3:0]  flush_cnt_q;

    logic        eq;
    logic        lt;
    logic        ltu;
    logic        bad_funct3;
    logic        cond;
    logic        take;
    logic [31:0] target_d;
    logic [15:0] count_d;

    always_comb begin
        eq         = (rs1_q == rs2_q);
        lt         = ($signed(rs1_q) < $signed(rs2_q));
        ltu        = (rs1_q < rs2_q);
        bad_funct3 = (funct3_q[2:1] == 2'b01);
        cond       = 1'b0;
        case (funct3_q)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b100:  cond = lt;
            3'b101:  cond = !lt;
            3'b110:  cond = ltu;
            3'b111:  cond = !ltu;
            default: cond = 1'b0;
        endcase
        take     = (state_q == EVAL) && cond;
        target_d = pc_q + imm_q;
        count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    end

    assign br.br_ready     = (state_q == IDLE);
    assign br.redir_valid  = (state_q == REDIRECT);
    assign br.flush        = (state_q == FLUSH);
    assign br.done         = (state_q == EVAL);
    assign br.taken        = take;
    assign br.illegal      = (state_q == EVAL) && bad_funct3;
    assign br.redir_target = target_q;
    assign br.taken_count  = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            funct3_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            target_q    <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (br.br_valid) begin
                        funct3_q <= br.br_funct3;
                        rs1_q    <= br.br_rs1;
                        rs2_q    <= br.br_rs2;
                        pc_q     <= br.br_pc;
                        imm_q    <= br.br_imm;
                        state_q  <= EVAL;
                    end
                end
                EVAL: begin
                    if (take) begin
                        target_q <= target_d;
                        count_q  <= count_d;
                        state_q  <= REDIRECT;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                REDIRECT: begin
                    // Target stays frozen in target_q until fetch takes it.
                    if (br.redir_ready) begin
                        flush_cnt_q <= FLUSH_LD;
                        state_q     <= (FLUSH_LD == 4'd0) ? IDLE : FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q <= 4'd1) begin
                        state_q <= IDLE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// Randomised scoreboard bench for branch_ctrl: stimulus pushes expected outcomes,
// a negedge monitor pops them and checks timing, redirect, flush and counter behaviour.
module tb_branch_ctrl;
    localparam int FLUSH_CYCLES = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    branch_ctrl_if br ();

    branch_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .br      (br)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        illegal;
        logic        taken;
        logic [31:0] target;
        logic [15:0] count;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   model_cnt = 0;
    int   rr_mode = 1;
    int   rr_cnt = 0;
    int   hs_cnt = 0;
    int   hs_seen = 0;
    bit   redir_pend = 1'b0;
    int   ready_due = -1;
    int   redir_due = -1;
    int   flush_left = -1;
    int   redir_len = 0;
    int   last_redir_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event seen/missing contrary to requirement (cycle %0d)", name, cyc);
    endtask

    // Reference outcome computed from the branch rules with wide plain arithmetic.
    function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] imm);
        exp_t   e;
        longint sa, sb, tgt;
        bit     t;
        sa = longint'(a);
        sb = longint'(b);
        if (a[31]) sa = sa - 64'sd4294967296;
        if (b[31]) sb = sb - 64'sd4294967296;
        case (f3)
            3'd0:    t = (a == b);
            3'd1:    t = (a != b);
            3'd4:    t = (sa < sb);
            3'd5:    t = (sa >= sb);
            3'd6:    t = (longint'(a) < longint'(b));
            3'd7:    t = (longint'(a) >= longint'(b));
            default: t = 1'b0;
        endcase
        tgt       = (longint'(pc) + longint'(imm)) % 64'sd4294967296;
        e.illegal = (f3 == 3'd2) || (f3 == 3'd3);
        e.taken   = t;
        e.target  = tgt[31:0];
        e.count   = '0;
        e.acc     = 0;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; offers junk while busy, then presents the real request.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm);
        exp_t e;
        int   guard;
        guard = 0;
        while (!br.br_ready && guard < 300) begin
            br.br_valid  = 1'($urandom_range(0, 1));
            br.br_funct3 = 3'($urandom);
            br.br_rs1    = $urandom;
            br.br_rs2    = $urandom;
            br.br_pc     = $urandom;
            br.br_imm    = $urandom;
            @(negedge clk);
            guard++;
        end
        if (!br.br_ready) begin
            fail("accept_timeout");
            br.br_valid = 1'b0;
            return;
        end
        e = model(f3, a, b, pc, imm);
        if (e.taken && model_cnt < 65535) model_cnt++;
        e.count = 16'(model_cnt);
        e.acc   = cyc + 1;
        sbq.push_back(e);
        br.br_valid  = 1'b1;
        br.br_funct3 = f3;
        br.br_rs1    = a;
        br.br_rs2    = b;
        br.br_pc     = pc;
        br.br_imm    = imm;
        @(negedge clk);
        br.br_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (!(sbq.size() == 0 && !redir_pend && flush_left < 0 && ready_due < 0 && br.br_ready)
               && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) fail("drain_timeout");
    endtask

    task automatic check_reset_vals();
        check("rst_br_ready", br.br_ready, 1);
        check("rst_redir_valid", br.redir_valid, 0);
        check("rst_flush", br.flush, 0);
        check("rst_done", br.done, 0);
        check("rst_taken", br.taken, 0);
        check("rst_illegal", br.illegal, 0);
        check("rst_redir_target", br.redir_target, 32'h0);
        check("rst_taken_count", br.taken_count, 32'h0);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset_n && br.redir_valid && br.redir_ready) hs_cnt++;
        if (cyc > 50000) begin
            $display("FAIL watchdog: cycle %0d, required below 50000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    always @(negedge clk) begin
        if (br.redir_valid) rr_cnt++;
        else rr_cnt = 0;
        case (rr_mode)
            0:       br.redir_ready = 1'($urandom_range(0, 1));
            1:       br.redir_ready = 1'b1;
            default: br.redir_ready = (rr_cnt >= 5);
        endcase
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            sbq.delete();
            redir_pend = 1'b0;
            ready_due  = -1;
            flush_left = -1;
            hs_seen    = hs_cnt;
        end else begin
            if (hs_seen != hs_cnt) begin
                hs_seen        = hs_cnt;
                redir_pend     = 1'b0;
                last_redir_len = redir_len;
                flush_left     = FLUSH_CYCLES;
            end
            if (br.done) begin
                if (sbq.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    cur = sbq.pop_front();
                    check("done_cycle", cyc, cur.acc);
                    check("taken", br.taken, cur.taken);
                    check("illegal", br.illegal, cur.illegal);
                    if (cur.taken) begin
                        redir_pend = 1'b1;
                        redir_due  = cyc + 1;
                        redir_len  = 0;
                    end else begin
                        ready_due = cyc + 1;
                    end
                end
            end else begin
                check("taken_outside_eval", br.taken, 0);
                check("illegal_outside_eval", br.illegal, 0);
            end
            if (cyc == ready_due) begin
                check("ready_after_resolve", br.br_ready, 1);
                check("count_not_taken", br.taken_count, cur.count);
                ready_due = -1;
            end
            if (br.redir_valid || (redir_pend && cyc >= redir_due)) begin
                check("redir_valid", br.redir_valid, redir_pend);
                if (redir_pend) begin
                    if (redir_len == 0) begin
                        check("redir_cycle", cyc, redir_due);
                        check("count_taken", br.taken_count, cur.count);
                    end
                    check("redir_target", br.redir_target, cur.target);
                    redir_len++;
                end
            end
            if (flush_left > 0) begin
                check("flush_on", br.flush, 1);
                flush_left--;
            end else begin
                check("flush_off", br.flush, 0);
                if (flush_left == 0) begin
                    check("ready_after_flush", br.br_ready, 1);
                    flush_left = -1;
                end
            end
        end
    end

    initial begin
        int g;
        logic [31:0] a, b;
        br.br_valid  = 1'b0;
        br.br_funct3 = '0;
        br.br_rs1    = '0;
        br.br_rs2    = '0;
        br.br_pc     = '0;
        br.br_imm    = '0;
        #1 reset_n = 1'b0;
        #1 check_reset_vals();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        rr_mode = 1;
        issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
        wait_idle();
        check("blt_count", br.taken_count, 1);

        issue(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20);
        wait_idle();

        rr_mode = 2;
        issue(3'b000, 32'd5, 32'd5, 32'hFFFF_FFF0, 32'h20);
        wait_idle();
        check("redir_hold_cycles", last_redir_len, 5);
        rr_mode = 1;

        issue(3'b010, $urandom, $urandom, $urandom, $urandom);
        wait_idle();
        check("illegal_count_kept", br.taken_count, 2);

        // Reset in the middle of the flush window must drop everything at once.
        issue(3'b101, 32'd5, 32'd3, 32'h2000, 32'h40);
        g = 0;
        while (!br.flush && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!br.flush) fail("flush_wait_timeout");
        check("count_before_reset", br.taken_count, 32'(model_cnt));
        #2 reset_n = 1'b0;
        #1 check_reset_vals();
        model_cnt = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        issue(3'b001, 32'd1, 32'd2, 32'h40, 32'h8);
        wait_idle();

        rr_mode = 0;
        for (int i = 0; i < 150; i++) begin
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            issue(3'($urandom_range(0, 7)), a, b, $urandom, pick());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        rr_mode = 1;
        @(negedge clk);
        wait_idle();
        force dut.count_q = 16'hFFF9;
        @(negedge clk);
        release dut.count_q;
        model_cnt = 32'hFFF9;
        @(negedge clk);
        check("count_preload", br.taken_count, 32'hFFF9);
        for (int i = 0; i < 8; i++) begin
            issue(3'b001, 32'(i + 1), 32'h0, $urandom, $urandom);
        end
        wait_idle();
        check("count_saturated", br.taken_count, 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles `flush` is held after a redirect is accepted (legal range 0..15).
REQ-002 SHALL have port `clk`, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `reset_n`, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 SHALL have port `br_valid`, input, 1 bit, meaning a branch request is offered.
REQ-005 SHALL have port `br_ready`, output, 1 bit, meaning the block can accept a request.
REQ-006 SHALL have port `br_funct3`, input, 3 bits, giving the branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-007 SHALL have ports `br_rs1` and `br_rs2`, inputs, 32 bits each, the compare operands.
REQ-008 SHALL have ports `br_pc` and `br_imm`, inputs, 32 bits each, the branch PC and the sign-extended offset.
REQ-009 SHALL have port `redir_valid`, output, 1 bit, meaning a fetch redirect is pending.
REQ-010 SHALL have port `redir_ready`, input, 1 bit, meaning fetch accepts the redirect.
REQ-011 SHALL have port `redir_target`, output, 32 bits, the redirect address.
REQ-012 SHALL have port `flush`, output, 1 bit, meaning kill younger pipeline instructions.
REQ-013 SHALL have ports `done`, `taken` and `illegal`, outputs, 1 bit each: a one-cycle resolution pulse, the outcome qualified by `done`, and a one-cycle bad-funct3 pulse.
REQ-014 SHALL have port `taken_count`, output, 16 bits, a saturating count of taken branches.

Function
REQ-015 SHALL implement the FSM states IDLE, EVAL, REDIRECT and FLUSH.
REQ-016 In IDLE, `br_ready` SHALL be 1; it SHALL be 0 in every other state.
REQ-017 When `br_valid` and `br_ready` are both 1 at an edge, the block SHALL register funct3, rs1, rs2, pc and imm, then go to EVAL.
REQ-018 In EVAL, the block SHALL compute from the registered operands only:
- eq = (rs1 == rs2)
- lt = signed(rs1) < signed(rs2)
- ltu = unsigned(rs1) < unsigned(rs2)
REQ-019 The taken decision SHALL be:
- BEQ: eq; BNE: !eq
- BLT: lt; BGE: !lt
- BLTU: ltu; BGEU: !ltu
REQ-020 In EVAL with funct3 010 or 011, the block SHALL pulse `illegal` and `done` for that cycle, keep `taken` at 0, and return to IDLE.
REQ-021 In EVAL when not taken, the block SHALL pulse `done` with `taken` = 0 and return to IDLE; `br_ready` SHALL be 1 two cycles after acceptance.
REQ-022 In EVAL when taken, the block SHALL:
- pulse `done` with `taken` = 1;
- register `redir_target` = pc + imm, modulo 2^32 with carry discarded;
- increment `taken_count`, saturating at 0xFFFF;
- go to REDIRECT, so `redir_valid` rises two cycles after acceptance.
REQ-023 In REDIRECT, `redir_valid` SHALL be 1 and `redir_target` SHALL stay stable until an edge where `redir_ready` = 1; `redir_valid` SHALL never drop before that handshake.
REQ-024 On the REDIRECT handshake, the block SHALL go to FLUSH with a down-counter loaded with FLUSH_CYCLES; if FLUSH_CYCLES = 0 it SHALL go directly to IDLE.
REQ-025 In FLUSH, `flush` SHALL be 1 for exactly FLUSH_CYCLES cycles, then the block SHALL enter IDLE.
REQ-026 `redir_ready` asserted outside REDIRECT SHALL be ignored.
REQ-027 `br_valid` while `br_ready` = 0 SHALL be ignored, and no request SHALL be lost or double-accepted.
REQ-028 `done`, `illegal` and `taken` SHALL be 0 in every cycle except the EVAL cycle.

Reset
REQ-029 Whenever `reset_n` = 0, regardless of clock or state, the block SHALL immediately go to IDLE and drive:
- `br_ready` = 1;
- `redir_valid`, `flush`, `done`, `taken`, `illegal` = 0;
- `redir_target` = 0x00000000;
- `taken_count` = 0x0000.
REQ-030 Reset asserted mid-REDIRECT or mid-FLUSH SHALL abandon the pending redirect; after release, no redirect or flush SHALL appear.
REQ-031 The first acceptance SHALL occur at the first rising edge after `reset_n` deasserts at which `br_valid` = 1.

Verification
REQ-032 BLT with rs1 = 0xFFFFFFFF, rs2 = 0x00000001, pc = 0x100, imm = 0x20, `redir_ready` = 1 -> `taken` = 1; `redir_valid` in cycle +2 with target 0x120; `flush` high 2 cycles; `taken_count` = 1.
REQ-033 BLTU with the same operands -> `done` with `taken` = 0, no redirect, `br_ready` = 1 in cycle +2.
REQ-034 BEQ, rs1 = rs2 = 5, pc = 0xFFFFFFF0, imm = 0x20, `redir_ready` held 0 for 4 cycles -> `redir_valid` and target 0x00000010 stable for 4 cycles; handshake on the 5th cycle.
REQ-035 funct3 = 010 -> `illegal` and `done` pulse once, `taken` = 0, no redirect, `taken_count` unchanged.
REQ-036 Reset asserted during FLUSH with `taken_count` = 3 -> all outputs at reset values immediately and `taken_count` = 0.
REQ-037 0x10005 taken BNE branches -> `taken_count` saturates at 0xFFFF.
